// File: rtl/cache_bus_arbiter_if.sv
// Signal bundle between the I/D caches, cache_bus_arbiter and the AXI bridge.
// slave: arbiter view; master: the caches/bridge environment driving it.
interface cache_bus_arbiter_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 cache_inst_req;
  logic                 cache_inst_wr;
  logic [1:0]           cache_inst_size;
  logic [BUS_WIDTH-1:0] cache_inst_addr;
  logic [BUS_WIDTH-1:0] cache_inst_wdata;
  logic [BUS_WIDTH-1:0] cache_inst_rdata;
  logic                 cache_inst_addr_ok;
  logic                 cache_inst_data_ok;

  logic                 cache_data_req;
  logic                 cache_data_wr;
  logic [1:0]           cache_data_size;
  logic [BUS_WIDTH-1:0] cache_data_addr;
  logic [BUS_WIDTH-1:0] cache_data_wdata;
  logic [BUS_WIDTH-1:0] cache_data_rdata;
  logic                 cache_data_addr_ok;
  logic                 cache_data_data_ok;

  logic                 bus_req;
  logic                 bus_wr;
  logic [1:0]           bus_size;
  logic [BUS_WIDTH-1:0] bus_addr;
  logic [BUS_WIDTH-1:0] bus_wdata;
  logic [BUS_WIDTH-1:0] bus_rdata;
  logic                 bus_addr_ok;
  logic                 bus_data_ok;

  modport slave (
    input  cache_inst_req, cache_inst_wr, cache_inst_size, cache_inst_addr, cache_inst_wdata,
    output cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok,
    input  cache_data_req, cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata,
    output cache_data_rdata, cache_data_addr_ok, cache_data_data_ok,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_rdata, bus_addr_ok, bus_data_ok
  );

  modport master (
    output cache_inst_req, cache_inst_wr, cache_inst_size, cache_inst_addr, cache_inst_wdata,
    input  cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok,
    output cache_data_req, cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata,
    input  cache_data_rdata, cache_data_addr_ok, cache_data_data_ok,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_rdata, bus_addr_ok, bus_data_ok
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto a single AXI-bridge port, one transaction at a time.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: D-cache priority).
module cache_bus_arbiter #(
  parameter int BUS_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  cache_bus_arbiter_if.slave bus_if
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic   grant_data;
  logic   addr_ok;
  logic   data_ok;

  logic                 sel_wr;
  logic [1:0]           sel_size;
  logic [BUS_WIDTH-1:0] sel_addr;
  logic [BUS_WIDTH-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_q, last_owner_d;
`endif

  always_comb begin
    grant_data = 1'b0;
    if (bus_if.cache_data_req && bus_if.cache_inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_data = (last_owner_q == OWN_INST);
`else
      grant_data = 1'b1;
`endif
    end else begin
      grant_data = bus_if.cache_data_req;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_if.cache_inst_req || bus_if.cache_data_req) begin
          owner_d = grant_data ? OWN_DATA : OWN_INST;
          state_d = ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = grant_data ? OWN_DATA : OWN_INST;
`endif
        end
      end
      ADDR: begin
        addr_ok = bus_if.bus_addr_ok;
        // A bridge may finish address and data in one beat; skip DATA then.
        if (bus_if.bus_addr_ok) begin
          if (bus_if.bus_data_ok) begin
            data_ok = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        data_ok = bus_if.bus_data_ok;
        if (bus_if.bus_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_INST;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_comb begin
    if (owner_q == OWN_DATA) begin
      sel_wr    = bus_if.cache_data_wr;
      sel_size  = bus_if.cache_data_size;
      sel_addr  = bus_if.cache_data_addr;
      sel_wdata = bus_if.cache_data_wdata;
    end else begin
      sel_wr    = bus_if.cache_inst_wr;
      sel_size  = bus_if.cache_inst_size;
      sel_addr  = bus_if.cache_inst_addr;
      sel_wdata = bus_if.cache_inst_wdata;
    end
  end

  assign bus_if.bus_req   = (state_q == ADDR);
  assign bus_if.bus_wr    = sel_wr;
  assign bus_if.bus_size  = sel_size;
  assign bus_if.bus_addr  = sel_addr;
  assign bus_if.bus_wdata = sel_wdata;

  // Handshakes only ever reach the current owner.
  assign bus_if.cache_inst_addr_ok = addr_ok && (owner_q == OWN_INST);
  assign bus_if.cache_inst_data_ok = data_ok && (owner_q == OWN_INST);
  assign bus_if.cache_data_addr_ok = addr_ok && (owner_q == OWN_DATA);
  assign bus_if.cache_data_data_ok = data_ok && (owner_q == OWN_DATA);

  assign bus_if.cache_inst_rdata = bus_if.bus_rdata;
  assign bus_if.cache_data_rdata = bus_if.bus_rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: vector table, directed sequences, random traffic vs a transaction-level model.
`timescale 1ns/1ps
module tb_cache_bus_arbiter;
  localparam int BW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_bus_arbiter_if #(.BUS_WIDTH(BW)) ifc ();
  cache_bus_arbiter #(.BUS_WIDTH(BW)) dut (.clk(clk), .rst(rst), .bus_if(ifc));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // exp bit order: {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
  task automatic check_oks(input string name, input logic [4:0] exp);
    check({name, ".bus_req"},      ifc.bus_req,            exp[4]);
    check({name, ".inst_addr_ok"}, ifc.cache_inst_addr_ok, exp[3]);
    check({name, ".inst_data_ok"}, ifc.cache_inst_data_ok, exp[2]);
    check({name, ".data_addr_ok"}, ifc.cache_data_addr_ok, exp[1]);
    check({name, ".data_data_ok"}, ifc.cache_data_data_ok, exp[0]);
  endtask

  task automatic idle_inputs();
    ifc.cache_inst_req = 0; ifc.cache_inst_wr = 0; ifc.cache_inst_size = 0;
    ifc.cache_inst_addr = 0; ifc.cache_inst_wdata = 0;
    ifc.cache_data_req = 0; ifc.cache_data_wr = 0; ifc.cache_data_size = 0;
    ifc.cache_data_addr = 0; ifc.cache_data_wdata = 0;
    ifc.bus_rdata = 0; ifc.bus_addr_ok = 0; ifc.bus_data_ok = 0;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model + agents ----------------
  int   m_busy, m_addr_done, m_owner, m_last;
  bit   req_on[2];
  bit   force_start[2];
  int   p_req, p_aok, p_dok;
  int   grants[$];
  logic prev_breq;

  task automatic model_reset();
    m_busy = 0; m_addr_done = 0; m_owner = 0; m_last = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    req_on[0] = 0; req_on[1] = 0;
    force_start[0] = 0; force_start[1] = 0;
    prev_breq = 1'b0;
    model_reset();
    drive_edge();
    drive_edge();
    rst = 1'b0;
  endtask

  function automatic int pick_owner(input logic ireq, input logic dreq);
    if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return dreq ? 1 : 0;
  endfunction

  task automatic agent_cycle();
    logic exp_breq, exp_aok, exp_dok;
    drive_edge();
    if (!req_on[0] && (force_start[0] || $urandom_range(99) < p_req)) begin
      req_on[0] = 1; force_start[0] = 0;
      ifc.cache_inst_wr    = 1'($urandom_range(1));
      ifc.cache_inst_size  = 2'($urandom_range(2));
      ifc.cache_inst_addr  = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      ifc.cache_inst_wdata = $urandom;
    end
    if (!req_on[1] && (force_start[1] || $urandom_range(99) < p_req)) begin
      req_on[1] = 1; force_start[1] = 0;
      ifc.cache_data_wr    = 1'($urandom_range(1));
      ifc.cache_data_size  = 2'($urandom_range(2));
      ifc.cache_data_addr  = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
      ifc.cache_data_wdata = $urandom;
    end
    ifc.cache_inst_req = req_on[0];
    ifc.cache_data_req = req_on[1];
    ifc.bus_addr_ok    = ifc.bus_req && ($urandom_range(99) < p_aok);
    ifc.bus_data_ok    = ($urandom_range(99) < p_dok);
    ifc.bus_rdata      = $urandom;

    @(negedge clk);
    exp_breq = (m_busy != 0) && (m_addr_done == 0);
    exp_aok  = exp_breq && ifc.bus_addr_ok;
    exp_dok  = (m_busy != 0) && ((m_addr_done != 0) ? ifc.bus_data_ok
                                                    : (ifc.bus_addr_ok && ifc.bus_data_ok));
    check_oks("rand", {exp_breq, exp_aok && m_owner == 0, exp_dok && m_owner == 0,
                       exp_aok && m_owner == 1, exp_dok && m_owner == 1});
    check("rand.inst_rdata", ifc.cache_inst_rdata, ifc.bus_rdata);
    check("rand.data_rdata", ifc.cache_data_rdata, ifc.bus_rdata);
    if (exp_breq) begin
      check("rand.bus_addr",  ifc.bus_addr,  m_owner == 1 ? ifc.cache_data_addr  : ifc.cache_inst_addr);
      check("rand.bus_wdata", ifc.bus_wdata, m_owner == 1 ? ifc.cache_data_wdata : ifc.cache_inst_wdata);
      check("rand.bus_wr",    ifc.bus_wr,    m_owner == 1 ? ifc.cache_data_wr    : ifc.cache_inst_wr);
      check("rand.bus_size",  ifc.bus_size,  m_owner == 1 ? ifc.cache_data_size  : ifc.cache_inst_size);
    end
    if (ifc.bus_req && !prev_breq) grants.push_back((ifc.bus_addr == ifc.cache_data_addr) ? 1 : 0);
    prev_breq = ifc.bus_req;
    if (ifc.cache_inst_addr_ok) req_on[0] = 0;
    if (ifc.cache_data_addr_ok) req_on[1] = 0;

    if (m_busy == 0) begin
      if (ifc.cache_inst_req || ifc.cache_data_req) begin
        m_owner = pick_owner(ifc.cache_inst_req, ifc.cache_data_req);
        m_last = m_owner; m_busy = 1; m_addr_done = 0;
      end
    end else if (m_addr_done == 0) begin
      if (ifc.bus_addr_ok) begin
        if (ifc.bus_data_ok) m_busy = 0;
        else m_addr_done = 1;
      end
    end else if (ifc.bus_data_ok) begin
      m_busy = 0;
    end
  endtask

  task automatic run_until_grants(input int want);
    int k = 0;
    while (grants.size() < want && k < 30) begin
      agent_cycle();
      k++;
    end
    if (grants.size() < want) check("grant_timeout", grants.size(), want);
  endtask

  task automatic check_grant(input int idx, input int exp);
    check($sformatf("grant_order[%0d]", idx),
          (idx < grants.size()) ? grants[idx] : 32'hFFFF_FFFF, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst;
    logic       ireq;
    logic       dreq;
    logic       aok;
    logic       dok;
    logic [4:0] exp;
  } row_t;

  row_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b10011};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10000};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10010};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};

    p_req = 0; p_aok = 0; p_dok = 0;
    reset_dut();
    @(negedge clk);
    check_oks("reset", 5'b00000);

    for (int i = 0; i < 16; i++) begin
      drive_edge();
      rst                = tbl[i].rst;
      ifc.cache_inst_req = tbl[i].ireq;
      ifc.cache_data_req = tbl[i].dreq;
      ifc.bus_addr_ok    = tbl[i].aok;
      ifc.bus_data_ok    = tbl[i].dok;
      @(negedge clk);
      check_oks($sformatf("row%0d", i), tbl[i].exp);
    end
    rst = 1'b0;

    // I-cache read, address accepted cycle 2, data returned cycle 4
    reset_dut();
    drive_edge();
    ifc.cache_inst_req = 1; ifc.cache_inst_addr = 32'hBFC0_0000;
    ifc.cache_inst_wr = 0; ifc.cache_inst_size = 2;
    @(negedge clk); check_oks("rd.c0", 5'b00000);
    drive_edge();
    @(negedge clk); check_oks("rd.c1", 5'b10000);
    check("rd.bus_addr", ifc.bus_addr, 32'hBFC0_0000);
    drive_edge();
    ifc.bus_addr_ok = 1;
    @(negedge clk); check_oks("rd.c2", 5'b11000);
    check("rd.bus_wr", ifc.bus_wr, 1'b0);
    drive_edge();
    ifc.cache_inst_req = 0; ifc.bus_addr_ok = 0;
    @(negedge clk); check_oks("rd.c3", 5'b00000);
    drive_edge();
    ifc.bus_data_ok = 1; ifc.bus_rdata = 32'h3C1D_0001;
    @(negedge clk); check_oks("rd.c4", 5'b00100);
    check("rd.inst_rdata", ifc.cache_inst_rdata, 32'h3C1D_0001);
    drive_edge();
    ifc.bus_data_ok = 0;
    @(negedge clk); check_oks("rd.c5", 5'b00000);

    // D-cache write with address and data accepted in the same cycle
    reset_dut();
    drive_edge();
    ifc.cache_data_req = 1; ifc.cache_data_wr = 1; ifc.cache_data_size = 2;
    ifc.cache_data_addr = 32'h0000_1000; ifc.cache_data_wdata = 32'hDEAD_BEEF;
    @(negedge clk); check_oks("wr.c0", 5'b00000);
    drive_edge();
    ifc.bus_addr_ok = 1; ifc.bus_data_ok = 1;
    @(negedge clk); check_oks("wr.c1", 5'b10011);
    check("wr.bus_addr",  ifc.bus_addr,  32'h0000_1000);
    check("wr.bus_wdata", ifc.bus_wdata, 32'hDEAD_BEEF);
    check("wr.bus_wr",    ifc.bus_wr,    1'b1);
    check("wr.bus_size",  ifc.bus_size,  2'd2);
    drive_edge();
    ifc.cache_data_req = 0; ifc.bus_addr_ok = 0; ifc.bus_data_ok = 0;
    @(negedge clk); check_oks("wr.c2", 5'b00000);
    drive_edge();
    @(negedge clk); check_oks("wr.c3", 5'b00000);

    // Simultaneous requests, four rounds: D-cache then I-cache each round
    reset_dut();
    grants.delete();
    p_req = 0; p_aok = 100; p_dok = 100;
    for (int r = 0; r < 4; r++) begin
      force_start[0] = 1; force_start[1] = 1;
      run_until_grants(grants.size() + 2);
    end
    for (int i = 0; i < 8; i++) check_grant(i, (i % 2 == 0) ? 1 : 0);

    // D-cache alone, then both: policy decides the contended grant
    reset_dut();
    grants.delete();
    force_start[1] = 1;
    run_until_grants(1);
    force_start[0] = 1; force_start[1] = 1;
    run_until_grants(3);
    check_grant(0, 1);
`ifdef ARB_ROUND_ROBIN_EN
    check_grant(1, 0);
    check_grant(2, 1);
`else
    check_grant(1, 1);
    check_grant(2, 0);
`endif

    // Random traffic against the model, stray data_ok included
    reset_dut();
    p_req = 30; p_aok = 50; p_dok = 40;
    for (int c = 0; c < 2000; c++) agent_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, width of the addr, wdata and rdata ports.
REQ-002 SHALL have port clk  in  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port cache_inst_req  in  1  I-cache request, held high until cache_inst_addr_ok.
REQ-005 SHALL have port cache_inst_wr  in  1  I-cache write flag.
REQ-006 SHALL have port cache_inst_size  in  2  I-cache size (0=byte, 1=half, 2=word).
REQ-007 SHALL have port cache_inst_addr  in  32  I-cache address.
REQ-008 SHALL have port cache_inst_wdata  in  32  I-cache write data.
REQ-009 SHALL have port cache_inst_rdata  out  32  read data to the I-cache.
REQ-010 SHALL have port cache_inst_addr_ok  out  1  I-cache address accepted.
REQ-011 SHALL have port cache_inst_data_ok  out  1  I-cache transaction complete.
REQ-012 SHALL have port cache_data_req  in  1  D-cache request, held high until cache_data_addr_ok.
REQ-013 SHALL have ports cache_data_wr (in, 1), cache_data_size (in, 2), cache_data_addr (in, 32) and cache_data_wdata (in, 32), with the same meanings as the inst counterparts.
REQ-014 SHALL have ports cache_data_rdata (out, 32), cache_data_addr_ok (out, 1) and cache_data_data_ok (out, 1), with the same meanings as the inst counterparts.
REQ-015 SHALL have ports bus_req, bus_wr, bus_size, bus_addr and bus_wdata, all outputs to the AXI bridge, with widths 1/1/2/32/32.
REQ-016 SHALL have ports bus_rdata (in, 32), bus_addr_ok (in, 1) and bus_data_ok (in, 1), all from the AXI bridge.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, ADDR, DATA; only one bus transaction is outstanding at a time.
REQ-018 SHALL, in IDLE with any request high, latch the granted owner into a register and move to ADDR on the next edge.
REQ-019 SHALL have no effect in IDLE with no request high; the FSM stays in IDLE.
REQ-020 SHALL drive bus_req = (state==ADDR); bus_wr, bus_size, bus_addr and bus_wdata SHALL be muxed from the owner's inputs.
REQ-021 SHALL, in ADDR, pass bus_addr_ok combinationally to the owner's addr_ok, then move to DATA.
REQ-022 SHALL, in ADDR when bus_addr_ok and bus_data_ok are high in the same cycle, pulse both the owner's addr_ok and data_ok and return to IDLE.
REQ-023 SHALL, in DATA, pass bus_data_ok combinationally to the owner's data_ok and return to IDLE on it.
REQ-024 SHALL drive bus_rdata unregistered onto both cache_inst_rdata and cache_data_rdata.
REQ-025 SHALL hold the non-owner's addr_ok and data_ok at 0 at all times.
REQ-026 SHALL give a 1-cycle latency from a request in IDLE to bus_req high.
REQ-027 SHALL allow a new grant in the cycle after returning to IDLE; there are no back-to-back grants from DATA.
REQ-028 SHALL treat a requester dropping req while in ADDR as a protocol violation with no recovery; bus_req stays high.
REQ-029 SHALL, with the default policy, use fixed priority when both requests are high in IDLE: the D-cache wins.

Reset
REQ-030 SHALL, on rst, set state=IDLE, owner=inst and last_owner=inst, and drive bus_req and every addr_ok/data_ok to 0 from the next cycle.
REQ-031 SHALL, if rst is asserted mid-transaction (ADDR/DATA), drop the transaction; any bus_data_ok that arrives later is ignored while in IDLE.

Configuration
REQ-032 SHALL, with macro ARB_ROUND_ROBIN_EN defined, grant round-robin on simultaneous requests: the requester that is not last_owner wins, and last_owner updates at each grant.
REQ-033 SHALL, without ARB_ROUND_ROBIN_EN, use fixed D-cache priority and compile out the last_owner register.

Verification
REQ-034 SHALL cover: inst_req=1, addr=0xBFC00000, wr=0; bus_addr_ok at cycle 2, bus_data_ok=1 with rdata=0x3C1D0001 at cycle 4 -> inst_data_ok pulse, cache_inst_rdata=0x3C1D0001, data_ok stays 0.
REQ-035 SHALL cover: inst_req and data_req both rise in cycle 0 -> bus_addr tracks cache_data_addr first; the inst transaction follows only after data_data_ok (default build).
REQ-036 SHALL cover: same stimulus as REQ-035 repeated 4 times with ARB_ROUND_ROBIN_EN defined -> grant order data, inst, data, inst.
REQ-037 SHALL cover: D-cache write wr=1, size=2, addr=0x00001000, wdata=0xDEADBEEF; bus_addr_ok and bus_data_ok in the same cycle -> data_addr_ok and data_data_ok both high that cycle, FSM returns to IDLE.
REQ-038 SHALL cover: rst pulsed during DATA, then a stray bus_data_ok -> all ok outputs stay 0 and bus_req=0.
